toggle_cdc_receiver: RTL and testbench

// Receive side of the toggle-based CDC link. Synchronizes the async toggle_in into clk,

---
 rtl/toggle_cdc_receiver.sv | 137 +++++++++++++
 tb/tb_toggle_cdc_receiver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_cdc_receiver.sv
// Receive side of a toggle-based CDC link: synchronises toggle_in, turns each level
// change into a one-cycle event and captures data_in into a show-ahead FIFO.
module toggle_cdc_receiver #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             toggle_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic [CNT_W-1:0] rx_count
);

  localparam int AW = $clog2(DEPTH);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_d_r;
  logic                   edge_s;

  logic [AW:0]            wr_ptr_r;
  logic [AW:0]            rd_ptr_r;
  logic [AW:0]            wr_ptr_nxt_s;
  logic [AW:0]            rd_ptr_nxt_s;
  logic [WIDTH-1:0]       mem_r [DEPTH];

  logic                   full_s;
  logic                   pop_s;
  logic                   push_s;
  logic                   drop_s;

  logic                   out_valid_r;
  logic [WIDTH-1:0]       out_data_r;
  logic [WIDTH-1:0]       head_nxt_s;
  logic                   overrun_r;
  logic                   overrun_nxt_s;
  logic [CNT_W-1:0]       rx_count_r;

  // Toggle synchroniser plus the delayed copy used for change detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r   <= '0;
      sync_d_r <= 1'b0;
    end else begin
      sync_r   <= {sync_r[SYNC_STAGES-2:0], toggle_in};
      sync_d_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign edge_s = sync_r[SYNC_STAGES-1] ^ sync_d_r;

  // FIFO control: push/pop decisions, next pointers and the next head word
  always_comb begin
    full_s        = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s         = out_valid_r & out_ready;
    push_s        = edge_s & (~full_s | pop_s);
    drop_s        = edge_s & full_s & ~pop_s;
    wr_ptr_nxt_s  = wr_ptr_r;
    rd_ptr_nxt_s  = rd_ptr_r;
    head_nxt_s    = '0;
    overrun_nxt_s = overrun_r;

    if (push_s) begin
      wr_ptr_nxt_s = wr_ptr_r + (AW+1)'(1);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end

    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + (AW+1)'(1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end

    // A word written this cycle into the slot that becomes the head must bypass memory
    if (wr_ptr_nxt_s == rd_ptr_nxt_s) begin
      head_nxt_s = '0;
    end else if (push_s && (wr_ptr_r[AW-1:0] == rd_ptr_nxt_s[AW-1:0])) begin
      head_nxt_s = data_in;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
    end

    if (drop_s) begin
      overrun_nxt_s = 1'b1;
    end else if (clr_overrun) begin
      overrun_nxt_s = 1'b0;
    end else begin
      overrun_nxt_s = overrun_r;
    end
  end

  // FIFO storage, written only on an accepted push
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= data_in;
    end
  end

  // Pointers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      overrun_r   <= 1'b0;
      rx_count_r  <= '0;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      out_valid_r <= (wr_ptr_nxt_s != rd_ptr_nxt_s);
      out_data_r  <= head_nxt_s;
      overrun_r   <= overrun_nxt_s;
      if (push_s) begin
        rx_count_r <= rx_count_r + CNT_W'(1);
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign overrun   = overrun_r;
  assign rx_count  = rx_count_r;

endmodule

// File: tb/tb_toggle_cdc_receiver.sv
// Self-checking bench for toggle_cdc_receiver: directed cases plus a randomised
// multi-ratio run, with a cycle model feeding a scoreboard of expected words.
module tb_toggle_cdc_receiver;

  localparam int WIDTH = 4;
  localparam int SYNC  = 2;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             toggle_in = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             out_ready = 1'b0;
  logic             clr_overrun = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             overrun;
  logic [CNT_W-1:0] rx_count;

  int half = 50;
  int n_vec = 0;
  int n_err = 0;
  bit src_done = 1'b0;

  // model state
  logic [SYNC-1:0]  m_sync;
  logic             m_d;
  int               m_count;
  logic             m_ovr;
  logic [CNT_W-1:0] m_rx;
  int               m_acc;
  int               m_drop;
  logic [WIDTH-1:0] exp_q [$];

  wire m_edge = m_sync[SYNC-1] ^ m_d;
  wire m_pop  = (m_count != 0) && out_ready;

  toggle_cdc_receiver #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .toggle_in(toggle_in), .data_in(data_in),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .overrun(overrun), .clr_overrun(clr_overrun), .rx_count(rx_count)
  );

  initial forever #(half) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic send(input logic [WIDTH-1:0] d);
    toggle_in = ~toggle_in;
    data_in   = d;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0; toggle_in = 1'b0; data_in = '0; out_ready = 1'b0; clr_overrun = 1'b0;
    repeat (2) @(posedge clk);
    #3; rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // cycle model of the receiver: pushes expected words on accepted events
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_sync <= '0; m_d <= 1'b0; m_count <= 0; m_ovr <= 1'b0; m_rx <= '0;
      m_acc <= 0; m_drop <= 0;
      exp_q.delete();
    end else begin
      m_sync <= {m_sync[SYNC-2:0], toggle_in};
      m_d    <= m_sync[SYNC-1];
      if (m_edge && (m_count < DEPTH || m_pop)) begin
        exp_q.push_back(data_in);
        m_rx    <= m_rx + 16'd1;
        m_acc   <= m_acc + 1;
        m_count <= m_pop ? m_count : m_count + 1;
      end else begin
        m_count <= m_pop ? m_count - 1 : m_count;
        if (m_edge) m_drop <= m_drop + 1;
      end
      if (m_edge && m_count >= DEPTH && !m_pop) m_ovr <= 1'b1;
      else if (clr_overrun) m_ovr <= 1'b0;
    end
  end

  // per-cycle comparison and scoreboard pop on each handshake
  always @(negedge clk) begin
    chk("valid", 32'(out_valid), 32'(m_count != 0));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    chk("rx_count", 32'(rx_count), 32'(m_rx));
    if (m_count != 0 && out_ready && exp_q.size() != 0) begin
      chk("sb_data", 32'(out_data), 32'(exp_q[0]));
      void'(exp_q.pop_front());
    end
  end

  initial begin
    #50_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // T1 single word latency and one-cycle valid pulse
    do_reset();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_rx", 32'(rx_count), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    out_ready = 1'b1;
    send(4'hA);
    @(posedge clk); @(posedge clk);
    @(negedge clk); chk("t1_early", 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'hA);
    chk("t1_rx", 32'(rx_count), 32'd1);
    chk("t1_ovr", 32'(overrun), 32'd0);
    @(posedge clk);
    @(negedge clk); chk("t1_pulse", 32'(out_valid), 32'd0);

    // T2 fill, overrun on fifth word, drain in order
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      send(4'(i));
      tick(6);
    end
    @(negedge clk);
    chk("t2_ovr", 32'(overrun), 32'd1);
    chk("t2_rx", 32'(rx_count), 32'd4);
    chk("t2_head", 32'(out_data), 32'd1);
    @(posedge clk); #1; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk); chk("t2_empty", 32'(out_valid), 32'd0);

    // T3 push into a full FIFO coinciding with a pop
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      send(4'(i));
      tick(6);
    end
    send(4'd5);
    @(posedge clk); @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t3_ovr", 32'(overrun), 32'd0);
    chk("t3_rx", 32'(rx_count), 32'd5);
    chk("t3_head", 32'(out_data), 32'd2);
    repeat (6) @(posedge clk);
    @(negedge clk); chk("t3_empty", 32'(out_valid), 32'd0);

    // T4 overrun set beats clear, then clear on a quiet cycle
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      send(4'(i));
      tick(6);
    end
    chk("t4_ovr_pre", 32'(overrun), 32'd1);
    send(4'd6);
    @(posedge clk); @(posedge clk); #1; clr_overrun = 1'b1;
    @(posedge clk);
    @(negedge clk); chk("t4_set_wins", 32'(overrun), 32'd1);
    @(posedge clk);
    @(negedge clk); chk("t4_cleared", 32'(overrun), 32'd0);
    chk("t4_rx", 32'(rx_count), 32'd4);
    @(posedge clk); #1; clr_overrun = 1'b0;

    // T5 asynchronous reset with words queued and a change in flight
    do_reset();
    send(4'd1); tick(6);
    send(4'd2); tick(6);
    chk("t5_pre_rx", 32'(rx_count), 32'd2);
    send(4'd3);
    @(posedge clk); #3;
    rst = 1'b0; toggle_in = 1'b0;
    #1;
    chk("t5_async_valid", 32'(out_valid), 32'd0);
    chk("t5_async_rx", 32'(rx_count), 32'd0);
    @(posedge clk); #3; rst = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("t5_quiet_valid", 32'(out_valid), 32'd0);
    chk("t5_quiet_rx", 32'(rx_count), 32'd0);

    // T6 random traffic at clk/source ratios 9/10 and 11/10
    for (int seg = 0; seg < 2; seg++) begin
      half = (seg == 0) ? 45 : 55;
      do_reset();
      src_done = 1'b0;
      fork
        begin
          for (int i = 0; i < 500; i++) begin
            send(4'($urandom_range(0, 15)));
            #(100 * $urandom_range(4, 12));
          end
          src_done = 1'b1;
        end
        begin
          while (!src_done) begin
            @(posedge clk); #2;
            out_ready = ($urandom_range(0, 15) == 0);
          end
        end
      join
      repeat (10) @(posedge clk);
      #2; out_ready = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("t6_drained", 32'(out_valid), 32'd0);
      chk("t6_rx_acc", 32'(rx_count), 32'(m_acc));
      chk("t6_ovr", 32'(overrun), 32'(m_drop != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
